// File: rtl/rr_grant_arbiter4_if.sv
// Request/grant bundle between four clients and the shared-resource arbiter.
// master = request side, slave = arbiter side.
interface rr_grant_arbiter4_if;
    logic [3:0] req;
    logic       rr_en;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       preempt;

    modport master (
        output req,
        output rr_en,
        input  gnt,
        input  gnt_id,
        input  gnt_valid,
        input  preempt
    );

    modport slave (
        input  req,
        input  rr_en,
        output gnt,
        output gnt_id,
        output gnt_valid,
        output preempt
    );
endinterface

// File: rtl/rr_grant_arbiter4.sv
// Purpose: four-client arbiter, fixed (req[3] highest) or round-robin order, with a hold-time limit.
// Latency: request to grant 1 cycle from IDLE; release drops the grant 1 cycle after req falls.
// Backpressure: clients hold req until done; an owner is preempted after MAX_HOLD cycles under contention.
module rr_grant_arbiter4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rr_grant_arbiter4_if.slave   bus
);

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
    localparam logic       HOLD_EN    = (MAX_HOLD != 0);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state_q,    state_d;
    logic [3:0] gnt_q,      gnt_d;
    logic [1:0] gnt_id_q,   gnt_id_d;
    logic       gnt_vld_q,  gnt_vld_d;
    logic       preempt_q,  preempt_d;
    logic [1:0] last_id_q,  last_id_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [1:0] mask_id_q,  mask_id_d;
    logic       mask_v_q,   mask_v_d;

    logic [3:0] cand;
    logic [3:0] owner_oh;
    logic [3:0] others;
    logic [1:0] winner;

    function automatic logic [3:0] onehot(input logic [1:0] id);
        onehot = 4'b0001 << id;
    endfunction

    // Highest set index wins, matching the 4-to-2 priority encoder.
    function automatic logic [1:0] fixed_pick(input logic [3:0] c);
        fixed_pick = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (c[i]) begin
                fixed_pick = 2'(i);
            end
        end
    endfunction

    // Ascending search starting just after the last owner, wrapping mod 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] c, input logic [1:0] last);
        logic [1:0] idx;
        logic       found;
        rr_pick = 2'd0;
        found   = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!found && c[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    always_comb begin
        cand     = bus.req & ~(mask_v_q ? onehot(mask_id_q) : 4'b0000);
        owner_oh = onehot(gnt_id_q);
        others   = bus.req & ~owner_oh;
        winner   = bus.rr_en ? rr_pick(cand, last_id_q) : fixed_pick(cand);
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        gnt_vld_d  = gnt_vld_q;
        preempt_d  = 1'b0;
        last_id_d  = last_id_q;
        hold_cnt_d = hold_cnt_q;
        mask_id_d  = mask_id_q;
        mask_v_d   = mask_v_q;

        unique case (state_q)
            IDLE: begin
                // The mask only ever influences this one decision.
                mask_v_d = 1'b0;
                if (cand != 4'b0000) begin
                    state_d    = GRANT;
                    gnt_d      = onehot(winner);
                    gnt_id_d   = winner;
                    gnt_vld_d  = 1'b1;
                    hold_cnt_d = 8'd1;
                end
            end

            GRANT: begin
                if (!bus.req[gnt_id_q]) begin
                    state_d   = IDLE;
                    gnt_d     = 4'b0000;
                    gnt_id_d  = 2'd0;
                    gnt_vld_d = 1'b0;
                    last_id_d = gnt_id_q;
                end else if (HOLD_EN && hold_cnt_q == HOLD_LIMIT && others != 4'b0000) begin
                    state_d   = IDLE;
                    gnt_d     = 4'b0000;
                    gnt_id_d  = 2'd0;
                    gnt_vld_d = 1'b0;
                    preempt_d = 1'b1;
                    last_id_d = gnt_id_q;
                    mask_id_d = gnt_id_q;
                    mask_v_d  = 1'b1;
                end else if (hold_cnt_q != 8'hFF) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= 4'b0000;
            gnt_id_q   <= 2'd0;
            gnt_vld_q  <= 1'b0;
            preempt_q  <= 1'b0;
            last_id_q  <= 2'd3;
            hold_cnt_q <= 8'd0;
            mask_id_q  <= 2'd0;
            mask_v_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            gnt_vld_q  <= gnt_vld_d;
            preempt_q  <= preempt_d;
            last_id_q  <= last_id_d;
            hold_cnt_q <= hold_cnt_d;
            mask_id_q  <= mask_id_d;
            mask_v_q   <= mask_v_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_vld_q;
    assign bus.preempt   = preempt_q;

endmodule

// File: tb/tb_rr_grant_arbiter4.sv
// Directed bench for rr_grant_arbiter4 with MAX_HOLD=4: vector table plus hand sequences.
module tb_rr_grant_arbiter4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rr_grant_arbiter4_if bus ();

    rr_grant_arbiter4 #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst_n;
        logic [3:0] req;
        logic       rr_en;
        logic [3:0] e_gnt;
        logic [1:0] e_id;
        logic       e_pre;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] q, input logic rr,
                       input logic [3:0] g, input logic [1:0] id, input logic p);
        vec_t v;
        v.rst_n = r; v.req = q; v.rr_en = rr;
        v.e_gnt = g; v.e_id = id; v.e_pre = p;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int idx, input logic [3:0] g,
                           input logic [1:0] id, input logic p);
        chk({tag, ".gnt"},       idx, bus.gnt, g);
        chk({tag, ".gnt_id"},    idx, {2'b00, bus.gnt_id}, {2'b00, id});
        chk({tag, ".gnt_valid"}, idx, {3'b000, bus.gnt_valid}, {3'b000, |g});
        chk({tag, ".preempt"},   idx, {3'b000, bus.preempt}, {3'b000, p});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.req = 4'b0000;
        bus.rr_en = 1'b0;

        // reset with all requests asserted, then fixed-mode grant to client 3
        add(0, 4'b1111, 0, 4'b0000, 2'd0, 0);
        add(0, 4'b1111, 0, 4'b0000, 2'd0, 0);
        add(1, 4'b1111, 0, 4'b1000, 2'd3, 0);
        add(1, 4'b0000, 0, 4'b0000, 2'd0, 0);
        // fixed priority 0110
        add(1, 4'b0110, 0, 4'b0100, 2'd2, 0);
        add(1, 4'b0110, 0, 4'b0100, 2'd2, 0);
        add(1, 4'b0010, 0, 4'b0000, 2'd0, 0);
        add(1, 4'b0010, 0, 4'b0010, 2'd1, 0);
        add(1, 4'b0000, 0, 4'b0000, 2'd0, 0);
        // hold limit with req=1001 constant
        add(1, 4'b1001, 0, 4'b1000, 2'd3, 0);
        add(1, 4'b1001, 0, 4'b1000, 2'd3, 0);
        add(1, 4'b1001, 0, 4'b1000, 2'd3, 0);
        add(1, 4'b1001, 0, 4'b1000, 2'd3, 0);
        add(1, 4'b1001, 0, 4'b0000, 2'd0, 1);
        add(1, 4'b1001, 0, 4'b0001, 2'd0, 0);
        add(1, 4'b1001, 0, 4'b0001, 2'd0, 0);
        add(1, 4'b1001, 0, 4'b0001, 2'd0, 0);
        add(1, 4'b1001, 0, 4'b0001, 2'd0, 0);
        add(1, 4'b1001, 0, 4'b0000, 2'd0, 1);
        add(1, 4'b1001, 0, 4'b1000, 2'd3, 0);
        add(1, 4'b0000, 0, 4'b0000, 2'd0, 0);
        // round-robin rotation 0,1,2,3,0
        add(1, 4'b1111, 1, 4'b0001, 2'd0, 0);
        add(1, 4'b1111, 1, 4'b0001, 2'd0, 0);
        add(1, 4'b1110, 1, 4'b0000, 2'd0, 0);
        add(1, 4'b1111, 1, 4'b0010, 2'd1, 0);
        add(1, 4'b1111, 1, 4'b0010, 2'd1, 0);
        add(1, 4'b1101, 1, 4'b0000, 2'd0, 0);
        add(1, 4'b1111, 1, 4'b0100, 2'd2, 0);
        add(1, 4'b1111, 1, 4'b0100, 2'd2, 0);
        add(1, 4'b1011, 1, 4'b0000, 2'd0, 0);
        add(1, 4'b1111, 1, 4'b1000, 2'd3, 0);
        add(1, 4'b1111, 1, 4'b1000, 2'd3, 0);
        add(1, 4'b0111, 1, 4'b0000, 2'd0, 0);
        add(1, 4'b1111, 1, 4'b0001, 2'd0, 0);
        add(1, 4'b0000, 1, 4'b0000, 2'd0, 0);

        foreach (vecs[i]) begin
            rst_n     = vecs[i].rst_n;
            bus.req   = vecs[i].req;
            bus.rr_en = vecs[i].rr_en;
            tick();
            chk_all("vec", i, vecs[i].e_gnt, vecs[i].e_id, vecs[i].e_pre);
        end

        // single requester never preempted, even well past the hold limit
        bus.rr_en = 1'b0;
        bus.req   = 4'b0100;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk_all("nocontend", c, 4'b0100, 2'd2, 1'b0);
        end
        bus.req = 4'b0000;
        tick();
        chk_all("nocontend_rel", 0, 4'b0000, 2'd0, 1'b0);

        // reset during a grant to client 1; rr search restarts at index 0
        bus.rr_en = 1'b1;
        bus.req   = 4'b0010;
        tick();
        chk_all("midgrant", 0, 4'b0010, 2'd1, 1'b0);
        rst_n = 1'b0;
        tick();
        chk_all("midreset", 0, 4'b0000, 2'd0, 1'b0);
        rst_n   = 1'b1;
        bus.req = 4'b1111;
        tick();
        chk_all("postreset_rr", 0, 4'b0001, 2'd0, 1'b0);
        bus.req = 4'b1110;
        tick();
        chk_all("postreset_rel", 0, 4'b0000, 2'd0, 1'b0);
        tick();
        chk_all("postreset_next", 0, 4'b0010, 2'd1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
